// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered sync, enable, position and strobes.
// Optional VGA_TIMING_LOOKAHEAD_EN adds Next_Col/Next_Row/Next_Ena for one-tick-ahead fetch.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int CNT_W    = 11
) (
  input  logic             Master_Clock_In,
  input  logic             Reset_In,
  output logic             Sync_Horiz_Out,
  output logic             Sync_Vert_Out,
  output logic             Disp_Ena_Out,
  output logic [CNT_W-1:0] Val_Col_Out,
  output logic [CNT_W-1:0] Val_Row_Out,
  output logic             Line_Start_Out,
  output logic             Frame_Start_Out,
  output logic             Pix_Tick_Out
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CNT_W-1:0] Next_Col_Out,
  output logic [CNT_W-1:0] Next_Row_Out,
  output logic             Next_Ena_Out
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  generate
    if (CLK_DIV < 1 || (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cfg
      $error("vga_timing_gen: CLK_DIV must be >= 1 and CNT_W must hold H_TOTAL-1 and V_TOTAL-1");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             tick;
  logic             h_vis, v_vis, h_sync, v_sync;

  // Compare in int so region ends equal to 2**CNT_W cannot overflow the counter width.
  function automatic logic in_range(input logic [CNT_W-1:0] p, input int lo, input int len);
    return (int'(p) >= lo) && (int'(p) < lo + len);
  endfunction

  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    h_vis  = in_range(h_cnt, 0, H_ACTIVE);
    v_vis  = in_range(v_cnt, 0, V_ACTIVE);
    h_sync = in_range(h_cnt, H_ACTIVE + H_FP, H_SYNC);
    v_sync = in_range(v_cnt, V_ACTIVE + V_FP, V_SYNC);
    h_nxt  = h_cnt + CNT_W'(1);
    v_nxt  = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      div_cnt         <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      Sync_Horiz_Out  <= ~H_POL;
      Sync_Vert_Out   <= ~V_POL;
      Disp_Ena_Out    <= 1'b0;
      Val_Col_Out     <= '0;
      Val_Row_Out     <= '0;
      Line_Start_Out  <= 1'b0;
      Frame_Start_Out <= 1'b0;
      Pix_Tick_Out    <= 1'b0;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      Next_Col_Out    <= '0;
      Next_Row_Out    <= '0;
      Next_Ena_Out    <= 1'b0;
`endif
    end else begin
      Pix_Tick_Out    <= 1'b0;
      Line_Start_Out  <= 1'b0;
      Frame_Start_Out <= 1'b0;
      if (tick) begin
        // Outputs present the pre-increment position; counters then advance.
        div_cnt         <= '0;
        Pix_Tick_Out    <= 1'b1;
        Line_Start_Out  <= (h_cnt == '0);
        Frame_Start_Out <= (h_cnt == '0) && (v_cnt == '0);
        Sync_Horiz_Out  <= h_sync ? H_POL : ~H_POL;
        Sync_Vert_Out   <= v_sync ? V_POL : ~V_POL;
        Disp_Ena_Out    <= h_vis && v_vis;
        Val_Col_Out     <= h_cnt;
        Val_Row_Out     <= v_cnt;
        h_cnt           <= h_nxt;
        v_cnt           <= v_nxt;
`ifdef VGA_TIMING_LOOKAHEAD_EN
        Next_Col_Out    <= h_nxt;
        Next_Row_Out    <= v_nxt;
        Next_Ena_Out    <= in_range(h_nxt, 0, H_ACTIVE) && in_range(v_nxt, 0, V_ACTIVE);
`endif
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode, CLK_DIV=4 mode and a tiny active-high mode short enough for whole frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // d1: defaults; d4: CLK_DIV=4; sm: 15x8 raster (H 8/2/3/2, V 4/1/2/1), active-high syncs.
  logic        d1_hs, d1_vs, d1_ena, d1_ls, d1_fs, d1_tk;
  logic [10:0] d1_col, d1_row;
  logic        d4_hs, d4_vs, d4_ena, d4_ls, d4_fs, d4_tk;
  logic [10:0] d4_col, d4_row;
  logic        sm_hs, sm_vs, sm_ena, sm_ls, sm_fs, sm_tk;
  logic [10:0] sm_col, sm_row;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [10:0] d1_ncol, d1_nrow, d4_ncol, d4_nrow, sm_ncol, sm_nrow;
  logic        d1_nena, d4_nena, sm_nena;
`endif

  vga_timing_gen u_d1 (
    .Master_Clock_In(clk), .Reset_In(rst),
    .Sync_Horiz_Out(d1_hs), .Sync_Vert_Out(d1_vs), .Disp_Ena_Out(d1_ena),
    .Val_Col_Out(d1_col), .Val_Row_Out(d1_row),
    .Line_Start_Out(d1_ls), .Frame_Start_Out(d1_fs), .Pix_Tick_Out(d1_tk)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .Next_Col_Out(d1_ncol), .Next_Row_Out(d1_nrow), .Next_Ena_Out(d1_nena)
`endif
  );

  vga_timing_gen #(.CLK_DIV(4)) u_d4 (
    .Master_Clock_In(clk), .Reset_In(rst),
    .Sync_Horiz_Out(d4_hs), .Sync_Vert_Out(d4_vs), .Disp_Ena_Out(d4_ena),
    .Val_Col_Out(d4_col), .Val_Row_Out(d4_row),
    .Line_Start_Out(d4_ls), .Frame_Start_Out(d4_fs), .Pix_Tick_Out(d4_tk)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .Next_Col_Out(d4_ncol), .Next_Row_Out(d4_nrow), .Next_Ena_Out(d4_nena)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_sm (
    .Master_Clock_In(clk), .Reset_In(rst),
    .Sync_Horiz_Out(sm_hs), .Sync_Vert_Out(sm_vs), .Disp_Ena_Out(sm_ena),
    .Val_Col_Out(sm_col), .Val_Row_Out(sm_row),
    .Line_Start_Out(sm_ls), .Frame_Start_Out(sm_fs), .Pix_Tick_Out(sm_tk)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .Next_Col_Out(sm_ncol), .Next_Row_Out(sm_nrow), .Next_Ena_Out(sm_nena)
`endif
  );

  task automatic check_reset_state(input string pfx);
    chk({pfx, " d1 ena"}, d1_ena, 0);
    chk({pfx, " d1 hs"}, d1_hs, 1);
    chk({pfx, " d1 vs"}, d1_vs, 1);
    chk({pfx, " d1 col"}, d1_col, 0);
    chk({pfx, " d1 row"}, d1_row, 0);
    chk({pfx, " d1 strobes"}, {d1_ls, d1_fs, d1_tk}, 0);
    chk({pfx, " d4 strobes"}, {d4_ls, d4_fs, d4_tk}, 0);
    chk({pfx, " sm hs/vs"}, {sm_hs, sm_vs}, 0);
`ifdef VGA_TIMING_LOOKAHEAD_EN
    chk({pfx, " sm next"}, {sm_ncol, sm_nrow, sm_nena}, 0);
`endif
  endtask

  task automatic check_first_tick(input string pfx);
    chk({pfx, " d1 frame"}, d1_fs, 1);
    chk({pfx, " d1 line"}, d1_ls, 1);
    chk({pfx, " d1 tick"}, d1_tk, 1);
    chk({pfx, " d1 col/row"}, {d1_col, d1_row}, 0);
    chk({pfx, " d1 ena"}, d1_ena, 1);
    chk({pfx, " sm frame"}, sm_fs, 1);
    chk({pfx, " d4 no tick yet"}, d4_tk, 0);
  endtask

  initial begin
    int ena_n, hs_n, hs_first, hs_last, ls_n, fs_n;
    int d4_tk_bad, d4_col_bad, d4_ena_n;
    int sm_ena_n, sm_hs_n, sm_vs_n, sm_fs_n, sm_pos_bad;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    int nx_bad = 0;
`endif
    ena_n = 0; hs_n = 0; hs_first = -1; hs_last = -1; ls_n = 0; fs_n = 0;
    d4_tk_bad = 0; d4_col_bad = 0; d4_ena_n = 0;
    sm_ena_n = 0; sm_hs_n = 0; sm_vs_n = 0; sm_fs_n = 0; sm_pos_bad = 0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_first_tick("release");

    // k counts negedges since the first post-release tick; d1 shows (k%800, k/800).
    for (int k = 0; k <= 3900; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 800) begin
        if (int'(d1_col) != k || d1_row != 0) ls_n += 100;
        if (d1_ena) ena_n++;
        if (!d1_hs) begin
          hs_n++;
          if (hs_first < 0) hs_first = k;
          hs_last = k;
        end
        if (d1_ls) ls_n++;
`ifdef VGA_TIMING_LOOKAHEAD_EN
        if (int'(d1_ncol) != (k + 1) % 800 || int'(d1_nrow) != (k + 1) / 800) nx_bad++;
`endif
      end
      if (k == 800) begin
        chk("d1 line wrap col", d1_col, 0);
        chk("d1 line wrap row", d1_row, 1);
        chk("d1 line start at 800", d1_ls, 1);
      end
      if (k < 3204 && d1_fs) fs_n++;
      if (k < 3204) begin
        if (d4_tk != (k % 4 == 3)) d4_tk_bad++;
        if (int'(d4_col) != ((k < 3) ? 0 : ((k - 3) / 4) % 800)) d4_col_bad++;
        if (k < 3203 && d4_ena) d4_ena_n++;
      end
      if (k == 3203) chk("d4 line start at 3203", d4_ls, 1);
      if (k < 120) begin
        if (int'(sm_col) != k % 15 || int'(sm_row) != k / 15) sm_pos_bad++;
        if (sm_ena) sm_ena_n++;
        if (sm_hs) sm_hs_n++;
        if (sm_vs) sm_vs_n++;
        if (sm_fs) sm_fs_n++;
`ifdef VGA_TIMING_LOOKAHEAD_EN
        if (int'(sm_ncol) != (k + 1) % 15 || int'(sm_nrow) != ((k + 1) / 15) % 8) nx_bad++;
        if (k == 119) chk("sm next after last", {sm_ncol, sm_nrow, sm_nena}, 1);
`endif
      end
      if (k == 120) begin
        chk("sm frame period", sm_fs, 1);
        chk("sm frame wrap pos", {sm_col, sm_row}, 0);
      end
    end

    chk("d1 ena clocks/line", ena_n, 640);
    chk("d1 hs low clocks", hs_n, 96);
    chk("d1 hs first col", hs_first, 656);
    chk("d1 hs last col", hs_last, 751);
    chk("d1 line start count+pos", ls_n, 1);
    chk("d1 frame starts", fs_n, 1);
    chk("d4 tick cadence", d4_tk_bad, 0);
    chk("d4 col hold", d4_col_bad, 0);
    chk("d4 ena clocks", d4_ena_n, 2560);
    chk("sm position", sm_pos_bad, 0);
    chk("sm ena clocks", sm_ena_n, 32);
    chk("sm hs high clocks", sm_hs_n, 24);
    chk("sm vs high clocks", sm_vs_n, 30);
    chk("sm frame starts", sm_fs_n, 1);
`ifdef VGA_TIMING_LOOKAHEAD_EN
    chk("lookahead tracking", nx_bad, 0);
`endif

    // Mid-frame reset at d1 (700, 4).
    chk("d1 pre-reset col", d1_col, 700);
    chk("d1 pre-reset row", d1_row, 4);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    rst = 1'b0;
    @(negedge clk);
    check_first_tick("restart");
    @(negedge clk);
    chk("restart d1 col 1", d1_col, 1);
    chk("restart d1 no frame", d1_fs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
